// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared types, widths, reset values and FSM encodings for the fetch queue
package inst_fetch_queue_pkg;
  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int MEMCTRL_INST_CNT = 4;
  localparam int FETCH_BURST_LEN = MEMCTRL_INST_CNT;
  localparam int IFQ_QUEUE_DEPTH = 16;
  typedef logic [INST_WIDTH-1:0] inst_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  localparam inst_t INST_RESET = '0;
  localparam addr_t ADDR_RESET = '0;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RECV    = 3'd2,
    RELEASE = 3'd3,
    ABORT   = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: memory-controller fetcher port, redirect input and decoder handshake
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  enable_to_memctrl;
  logic [ADDR_WIDTH-1:0] address_to_memctrl;
  logic                  reset_to_memctrl;
  logic                  aviliable_from_memctrl;
  logic                  one_inst_finish_from_memctrl;
  inst_t                 inst_from_memctrl;
  logic                  end_from_memctrl;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid_to_decoder;
  inst_t                 inst_to_decoder;
  logic [ADDR_WIDTH-1:0] pc_to_decoder;
  logic                  inst_ready_from_decoder;
  modport master (
    output enable_to_memctrl, address_to_memctrl, reset_to_memctrl,
    output inst_valid_to_decoder, inst_to_decoder, pc_to_decoder,
    input  aviliable_from_memctrl, one_inst_finish_from_memctrl, inst_from_memctrl, end_from_memctrl,
    input  redirect_valid, redirect_pc, inst_ready_from_decoder
  );
  modport slave (
    input  enable_to_memctrl, address_to_memctrl, reset_to_memctrl,
    input  inst_valid_to_decoder, inst_to_decoder, pc_to_decoder,
    output aviliable_from_memctrl, one_inst_finish_from_memctrl, inst_from_memctrl, end_from_memctrl,
    output redirect_valid, redirect_pc, inst_ready_from_decoder
  );
endinterface

// File: rtl/inst_queue_fifo.sv
// inst_queue_fifo: circular FIFO with push/pop/flush, occupancy count and combinational head read
module inst_queue_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop, do_flush;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem[head_q];
  // flush wins over push/pop; pointers wrap naturally at DEPTH
  always_comb begin
    do_flush = en && flush;
    do_push  = en && push && !do_flush;
    do_pop   = en && pop && !do_flush && !empty;
    head_d   = do_flush ? tail_q : head_q + AW'(do_pop);
    tail_d   = tail_q + AW'(do_push);
    count_d  = do_flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // storage array; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_q] <= din;
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(do_push && full && !do_pop));
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: burst instruction fetcher feeding a decoder through a circular instruction queue
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = IFQ_QUEUE_DEPTH,
  parameter int BURST_LEN   = FETCH_BURST_LEN,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input logic                clk_in,
  input logic                rst_in,
  input logic                rdy_in,
  inst_fetch_queue_if.master bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int EW = INST_WIDTH + ADDR_WIDTH;
  fetch_state_e          state_q, state_d;
  logic                  enable_q, enable_d, rst_mc_q, rst_mc_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d, fetch_pc_q, fetch_pc_d;
  logic [BW-1:0]         burst_idx_q, burst_idx_d;
  logic [CW-1:0]         count;
  logic [CW:0]           free_slots;
  logic                  redirect, push, pop, flush, start, in_burst, full, empty;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [EW-1:0]         head;
  inst_queue_fifo #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_fifo (
    .clk(clk_in), .rst(rst_in), .en(rdy_in), .push(push), .pop(pop), .flush(flush),
    .din({bus.inst_from_memctrl, push_pc}), .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign bus.enable_to_memctrl     = enable_q;
  assign bus.address_to_memctrl    = address_q;
  assign bus.reset_to_memctrl      = rst_mc_q;
  assign bus.inst_valid_to_decoder = !empty;
  assign bus.inst_to_decoder       = empty ? INST_RESET : head[EW-1:ADDR_WIDTH];
  assign bus.pc_to_decoder         = empty ? ADDR_WIDTH'(ADDR_RESET) : head[ADDR_WIDTH-1:0];
  // queue handshakes; a redirect suppresses both push and pop, and a same-cycle pop frees a slot
  always_comb begin
    redirect   = bus.redirect_valid;
    in_burst   = state_q == REQ || state_q == RECV;
    pop        = rdy_in && !redirect && !empty && bus.inst_ready_from_decoder;
    push       = rdy_in && !redirect && state_q == RECV && bus.one_inst_finish_from_memctrl;
    flush      = rdy_in && redirect;
    free_slots = (CW+1)'(QUEUE_DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    start      = bus.aviliable_from_memctrl && free_slots >= (CW+1)'(BURST_LEN);
    push_pc    = address_q + (ADDR_WIDTH'(burst_idx_q) << 2);
  end
  // state register plus burst datapath flops, frozen while rdy_in is low
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      rst_mc_q    <= 1'b0;
      address_q   <= ADDR_WIDTH'(ADDR_RESET);
      fetch_pc_q  <= ADDR_WIDTH'(ADDR_RESET);
      burst_idx_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      rst_mc_q    <= rst_mc_d;
      address_q   <= address_d;
      fetch_pc_q  <= fetch_pc_d;
      burst_idx_q <= burst_idx_d;
    end
  end
  // next state; redirect aborts an active burst and otherwise leaves the state alone
  always_comb begin
    state_d = state_q;
    if (redirect) state_d = in_burst ? ABORT : state_q;
    else
      case (state_q)
        IDLE:    state_d = start ? REQ : IDLE;
        REQ:     state_d = bus.aviliable_from_memctrl ? REQ : RECV;
        RECV:    state_d = bus.end_from_memctrl ? RELEASE : RECV;
        RELEASE: state_d = bus.aviliable_from_memctrl ? IDLE : RELEASE;
        ABORT:   state_d = bus.aviliable_from_memctrl ? IDLE : ABORT;
        default: state_d = IDLE;
      endcase
  end
  // request outputs, burst index and next fetch PC
  always_comb begin
    enable_d    = enable_q;
    address_d   = address_q;
    fetch_pc_d  = fetch_pc_q;
    burst_idx_d = burst_idx_q;
    rst_mc_d    = 1'b0;
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc;
      enable_d   = in_burst ? 1'b0 : enable_q;
      rst_mc_d   = in_burst;
    end else if (state_q == IDLE && start) begin
      enable_d    = 1'b1;
      address_d   = fetch_pc_q;
      burst_idx_d = '0;
    end else if (state_q == RECV) begin
      burst_idx_d = burst_idx_q + BW'(push);
      enable_d    = bus.end_from_memctrl ? 1'b0 : enable_q;
      fetch_pc_d  = bus.end_from_memctrl ? address_q + ADDR_WIDTH'(4 * BURST_LEN) : fetch_pc_q;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: reactive memory-controller model with a scoreboard of expected decoder output
module tb_inst_fetch_queue;
  localparam int BL = 4;
  typedef enum {M_IDLE, M_DATA, M_DONE, M_ABRT} mst_e;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in;
  inst_fetch_queue_if #(.ADDR_WIDTH(32)) bus();
  inst_fetch_queue #(.QUEUE_DEPTH(16), .BURST_LEN(BL), .ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus.master)
  );
  always #5 clk_in = ~clk_in;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  mst_e mst;
  int k, bursts, b0;
  logic [31:0] base, exp_fetch_pc, dat, redir_pc;
  logic exp_pulse, ready, redir;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE;
    k = 0;
    sb.delete();
    exp_fetch_pc = 32'h0;
    exp_pulse = 1'b0;
    bus.aviliable_from_memctrl = 1'b1;
    bus.one_inst_finish_from_memctrl = 1'b0;
    bus.end_from_memctrl = 1'b0;
    bus.inst_from_memctrl = 32'h0;
  endtask

  task automatic tick();
    logic [63:0] e;
    logic np;
    bus.one_inst_finish_from_memctrl = 1'b0;
    bus.end_from_memctrl = 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc = redir_pc;
    bus.inst_ready_from_decoder = ready;
    if (rdy_in) begin
      chk("valid", 64'(bus.inst_valid_to_decoder), 64'(sb.size() != 0));
      chk("reset_pulse", 64'(bus.reset_to_memctrl), 64'(exp_pulse));
      if (sb.size() != 0 && ready && !redir) begin
        e = sb.pop_front();
        chk("inst", 64'(bus.inst_to_decoder), 64'(e[63:32]));
        chk("pc", 64'(bus.pc_to_decoder), 64'(e[31:0]));
      end
      np = 1'b0;
      case (mst)
        M_IDLE: if (bus.enable_to_memctrl) begin
          chk("burst_addr", 64'(bus.address_to_memctrl), 64'(exp_fetch_pc));
          base = exp_fetch_pc;
          bus.aviliable_from_memctrl = 1'b0;
          k = 0;
          bursts++;
          mst = M_DATA;
          np = redir;
        end
        M_DATA: if (exp_pulse) begin
          bus.one_inst_finish_from_memctrl = 1'b1;
          bus.inst_from_memctrl = 32'hdeadbeef;
          mst = M_ABRT;
        end else begin
          bus.one_inst_finish_from_memctrl = 1'b1;
          bus.inst_from_memctrl = dat * 32'h11;
          dat++;
          if (!redir) sb.push_back({bus.inst_from_memctrl, base + 32'(4 * k)});
          k++;
          np = redir;
          if (k == BL) begin
            bus.end_from_memctrl = 1'b1;
            exp_fetch_pc = base + 32'(4 * BL);
            mst = M_DONE;
          end
        end
        default: begin
          bus.aviliable_from_memctrl = 1'b1;
          mst = M_IDLE;
        end
      endcase
      if (redir) begin
        sb.delete();
        exp_fetch_pc = redir_pc;
      end
      exp_pulse = np;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic wait_k(int n);
    for (int i = 0; i < 200; i++) begin
      if (mst == M_DATA && k == n) return;
      tick();
    end
    chk("wait_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    rdy_in = 1'b1;
    ready = 1'b0;
    redir = 1'b0;
    redir_pc = 32'h0;
    dat = 32'd1;
    bursts = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready_from_decoder = 1'b0;
    model_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_enable", 64'(bus.enable_to_memctrl), 64'(0));
    chk("rst_address", 64'(bus.address_to_memctrl), 64'(0));
    chk("rst_reset_mc", 64'(bus.reset_to_memctrl), 64'(0));
    chk("rst_valid", 64'(bus.inst_valid_to_decoder), 64'(0));
    chk("rst_inst", 64'(bus.inst_to_decoder), 64'(0));
    chk("rst_pc", 64'(bus.pc_to_decoder), 64'(0));
    rst_in = 1'b0;
    repeat (40) tick();
    chk("bursts_to_full", 64'(bursts), 64'(4));
    chk("full_no_req", 64'(bus.enable_to_memctrl), 64'(0));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (4) begin
      chk("no_req_free1", 64'(bus.enable_to_memctrl), 64'(0));
      tick();
    end
    ready = 1'b1;
    repeat (2) tick();
    ready = 1'b0;
    repeat (3) begin
      chk("no_req_free3", 64'(bus.enable_to_memctrl), 64'(0));
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("req_on_pop", 64'(bus.enable_to_memctrl), 64'(1));
    ready = 1'b1;
    repeat (60) tick();
    wait_k(2);
    redir = 1'b1;
    redir_pc = 32'h100;
    tick();
    redir = 1'b0;
    b0 = bursts;
    repeat (20) tick();
    chk("refetch_after_redirect", 64'(bursts > b0), 64'(1));
    wait_k(3);
    redir = 1'b1;
    redir_pc = 32'h200;
    tick();
    redir = 1'b0;
    b0 = bursts;
    repeat (20) tick();
    chk("refetch_after_end_redirect", 64'(bursts > b0), 64'(1));
    wait_k(2);
    rdy_in = 1'b0;
    repeat (5) begin
      chk("frozen_enable", 64'(bus.enable_to_memctrl), 64'(1));
      tick();
    end
    rdy_in = 1'b1;
    repeat (30) tick();
    wait_k(2);
    #2 rst_in = 1'b1;
    #1;
    chk("async_enable", 64'(bus.enable_to_memctrl), 64'(0));
    chk("async_address", 64'(bus.address_to_memctrl), 64'(0));
    chk("async_valid", 64'(bus.inst_valid_to_decoder), 64'(0));
    chk("async_inst", 64'(bus.inst_to_decoder), 64'(0));
    chk("async_pc", 64'(bus.pc_to_decoder), 64'(0));
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (30) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
